// File: rtl/pixel_receiver.sv
// pixel_receiver: decodes the first pixel of each WS2812B frame from an
// asynchronous serial line and presents it on a valid/ready handshake.
// Build option: define PIXEL_RECEIVER_FWD_EN to forward the remainder of the
// frame (everything after this device's pixel) on dout; otherwise dout is 0.
module pixel_receiver #(
  parameter int TCK_THRESH    = 9,
  parameter int TCK_MAX_HI    = 16,
  parameter int TCK_RESET_MIN = 400,
  parameter int CNT_COLOR     = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       valid,
  input  logic       ready,
  output logic       frame_start,
  output logic       error,
  output logic       dout
);

  localparam int LO_W = $clog2(TCK_RESET_MIN + 1);
  localparam int HI_W = $clog2(TCK_MAX_HI + 2);
  localparam int BC_W = $clog2(CNT_COLOR);

  localparam logic [LO_W-1:0] LO_MAX   = LO_W'(TCK_RESET_MIN);
  localparam logic [LO_W-1:0] LO_TRIG  = LO_W'(TCK_RESET_MIN - 1);
  localparam logic [HI_W-1:0] HI_SAT   = HI_W'(TCK_MAX_HI + 1);
  localparam logic [HI_W-1:0] HI_MAX   = HI_W'(TCK_MAX_HI);
  localparam logic [HI_W-1:0] HI_THR   = HI_W'(TCK_THRESH);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(CNT_COLOR - 1);

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  // Saturating increment for the low-time counter.
  function automatic logic [LO_W-1:0] sat_inc_lo(input logic [LO_W-1:0] v);
    return (v >= LO_MAX) ? LO_MAX : v + 1'b1;
  endfunction

  // Saturating increment for the high-time counter.
  function automatic logic [HI_W-1:0] sat_inc_hi(input logic [HI_W-1:0] v);
    return (v >= HI_SAT) ? HI_SAT : v + 1'b1;
  endfunction

  logic                 din_p0, din_p1;
  logic                 din_s;
  state_t               state, state_nxt;
  logic [LO_W-1:0]      lo_cnt, lo_cnt_nxt;
  logic [HI_W-1:0]      hi_cnt, hi_cnt_nxt;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic                 first_done, first_done_nxt;
  logic [CNT_COLOR-2:0] shreg, shreg_nxt;
  logic [CNT_COLOR-1:0] pix_nxt;
  logic                 bit_val;
  logic                 fs_nxt, err_nxt, load;
  logic                 fs_p2, err_p2, vld_p2;
  logic [23:0]          pix_p2;

  assign din_s = din_p1;

  // Stage p0/p1: two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
    end else begin
      din_p0 <= din;
      din_p1 <= din_p0;
    end
  end

  // Pulse-timing FSM: next state, counters, bit decode and event pulses.
  always_comb begin
    state_nxt      = state;
    lo_cnt_nxt     = lo_cnt;
    hi_cnt_nxt     = hi_cnt;
    bit_cnt_nxt    = bit_cnt;
    first_done_nxt = first_done;
    shreg_nxt      = shreg;
    fs_nxt         = 1'b0;
    err_nxt        = 1'b0;
    load           = 1'b0;
    bit_val        = (hi_cnt >= HI_THR);
    pix_nxt        = {shreg, bit_val};
    case (state)
      SYNC: begin
        if (din_s) begin
          lo_cnt_nxt = '0;
        end else if (lo_cnt == LO_TRIG) begin
          // Line has been idle long enough: lock on and open a new frame.
          lo_cnt_nxt     = LO_MAX;
          state_nxt      = LOW;
          fs_nxt         = 1'b1;
          bit_cnt_nxt    = '0;
          first_done_nxt = 1'b0;
        end else begin
          lo_cnt_nxt = sat_inc_lo(lo_cnt);
        end
      end
      LOW: begin
        if (din_s) begin
          state_nxt  = HIGH;
          hi_cnt_nxt = '0;
          lo_cnt_nxt = '0;
        end else if (lo_cnt == LO_TRIG) begin
          // Frame reset; a partly received pixel is reported as truncated.
          lo_cnt_nxt     = LO_MAX;
          fs_nxt         = 1'b1;
          err_nxt        = (bit_cnt != '0);
          bit_cnt_nxt    = '0;
          first_done_nxt = 1'b0;
        end else begin
          lo_cnt_nxt = sat_inc_lo(lo_cnt);
        end
      end
      HIGH: begin
        if (hi_cnt > HI_MAX) begin
          // Malformed pulse: drop the pixel and resynchronise on a long low.
          state_nxt   = SYNC;
          err_nxt     = 1'b1;
          bit_cnt_nxt = '0;
          lo_cnt_nxt  = '0;
        end else if (din_s) begin
          hi_cnt_nxt = sat_inc_hi(hi_cnt);
        end else begin
          state_nxt  = LOW;
          lo_cnt_nxt = LO_W'(1);
          if (!first_done) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt_nxt    = '0;
              first_done_nxt = 1'b1;
              if (!vld_p2 || ready) begin
                load = 1'b1;
              end else begin
                err_nxt = 1'b1;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
              shreg_nxt   = pix_nxt[CNT_COLOR-2:0];
            end
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Stage p2 control: FSM state, counters and registered event pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= SYNC;
      lo_cnt     <= '0;
      hi_cnt     <= '0;
      bit_cnt    <= '0;
      first_done <= 1'b0;
      fs_p2      <= 1'b0;
      err_p2     <= 1'b0;
    end else begin
      state      <= state_nxt;
      lo_cnt     <= lo_cnt_nxt;
      hi_cnt     <= hi_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      first_done <= first_done_nxt;
      fs_p2      <= fs_nxt;
      err_p2     <= err_nxt;
    end
  end

  // Stage p2 data: bit shift register; the bit counter qualifies its contents.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  // Stage p2 output: pixel holding register and valid/ready handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p2 <= 1'b0;
      pix_p2 <= '0;
    end else if (load) begin
      vld_p2 <= 1'b1;
      pix_p2 <= pix_nxt[23:0];
    end else if (vld_p2 && ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign green       = pix_p2[23:16];
  assign red         = pix_p2[15:8];
  assign blue        = pix_p2[7:0];
  assign valid       = vld_p2;
  assign frame_start = fs_p2;
  assign error       = err_p2;

`ifdef PIXEL_RECEIVER_FWD_EN
  assign dout = first_done & din_s;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_receiver.sv
// tb_pixel_receiver: directed-vector bench for pixel_receiver.
module tb_pixel_receiver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       din;
  logic       ready;
  logic [7:0] red, green, blue;
  logic       valid, frame_start, error, dout;

  always #5 clk = ~clk;

  pixel_receiver dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .valid       (valid),
    .ready       (ready),
    .frame_start (frame_start),
    .error       (error),
    .dout        (dout)
  );

  localparam logic [23:0] PIX_A = 24'hA53C0F;
  localparam logic [23:0] PIX_B = 24'h123456;
  localparam logic [23:0] PIX_C = 24'h0F0F0F;
  localparam logic [23:0] PIX_D = 24'h5A5A5A;
  localparam logic [23:0] PIX_E = 24'hC3C3C3;
  localparam logic [23:0] PIX_F = 24'h112233;
  localparam logic [23:0] PIX_G = 24'h445566;

  int n_chk = 0;
  int n_err = 0;

  // Event counters sampled on the falling edge, away from the active edge.
  int          acc_cnt = 0;
  int          fs_cnt = 0;
  int          err_cnt = 0;
  int          fs_err_cnt = 0;
  int          dout_hi = 0;
  logic [23:0] acc_pix = '0;

  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      acc_cnt++;
      acc_pix = {green, red, blue};
    end
    if (frame_start === 1'b1) fs_cnt++;
    if (error === 1'b1) err_cnt++;
    if (frame_start === 1'b1 && error === 1'b1) fs_err_cnt++;
    if (dout === 1'b1) dout_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_low(input int n);
    din = 1'b0;
    repeat (n) tick();
  endtask

  // One WS2812B bit: 18-tick period, high 11 ticks for a 1 and 6 for a 0.
  task automatic send_bit(input logic b);
    din = 1'b1;
    repeat (b ? 11 : 6) tick();
    din = 1'b0;
    repeat (b ? 7 : 12) tick();
  endtask

  task automatic send_range(input logic [23:0] pix, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(pix[i]);
  endtask

  // Sends a pixel tick by tick and counts cycles where dout differs from the
  // line value two ticks earlier (forwarding build) or from 0 (default build).
  task automatic send_fwd(input logic [23:0] pix, output int bad);
    logic dprev;
    logic expv;
    int   nh;
    bad   = 0;
    dprev = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      nh = pix[i] ? 11 : 6;
      for (int t = 0; t < 18; t++) begin
        din = (t < nh);
        tick();
`ifdef PIXEL_RECEIVER_FWD_EN
        expv = dprev;
`else
        expv = 1'b0;
`endif
        if (dout !== expv) bad++;
        dprev = din;
      end
    end
  endtask

  int a0, f0, e0, fe0, d0, bad;

  initial begin
    reset_n = 1'b0;
    din     = 1'b0;
    ready   = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_rgb", 32'({green, red, blue}), 32'd0);

    // Basic pixel with valid latency from the raw falling edge of the last bit.
    a0 = acc_cnt; f0 = fs_cnt; e0 = err_cnt;
    reset_n = 1'b1;
    idle_low(450);
    send_range(PIX_A, 23, 1);
    din = 1'b1;
    repeat (11) tick();
    din = 1'b0;
    tick();
    tick();
    chk("lat_early", 32'(valid), 32'd0);
    tick();
    chk("lat_valid", 32'(valid), 32'd1);
    chk("t1_green", 32'(green), 32'hA5);
    chk("t1_red", 32'(red), 32'h3C);
    chk("t1_blue", 32'(blue), 32'h0F);
    tick();
    chk("valid_1cyc", 32'(valid), 32'd0);
    idle_low(20);
    chk("t1_fs", 32'(fs_cnt - f0), 32'd1);
    chk("t1_err", 32'(err_cnt - e0), 32'd0);
    chk("t1_acc", 32'(acc_cnt - a0), 32'd1);
    chk("t1_pix", 32'(acc_pix), 32'(PIX_A));

    // Back-pressure: hold for 100 cycles, then accept.
    idle_low(450);
    ready = 1'b0;
    a0 = acc_cnt; e0 = err_cnt;
    send_range(PIX_A, 23, 0);
    chk("t2_valid_up", 32'(valid), 32'd1);
    bad = 0;
    repeat (100) begin
      tick();
      if (valid !== 1'b1 || {green, red, blue} !== PIX_A) bad++;
    end
    chk("t2_hold", 32'(bad), 32'd0);
    chk("t2_no_acc", 32'(acc_cnt - a0), 32'd0);
    ready = 1'b1;
    tick();
    chk("t2_drop", 32'(valid), 32'd0);
    chk("t2_acc", 32'(acc_cnt - a0), 32'd1);
    chk("t2_err", 32'(err_cnt - e0), 32'd0);

    // Truncated pixel: 12 bits then a frame reset.
    idle_low(450);
    a0 = acc_cnt; f0 = fs_cnt; e0 = err_cnt; fe0 = fs_err_cnt;
    send_range(PIX_B, 23, 12);
    idle_low(450);
    chk("t3_fs", 32'(fs_cnt - f0), 32'd1);
    chk("t3_err", 32'(err_cnt - e0), 32'd1);
    chk("t3_same_cyc", 32'(fs_err_cnt - fe0), 32'd1);
    chk("t3_no_acc", 32'(acc_cnt - a0), 32'd0);
    send_range(PIX_B, 23, 0);
    idle_low(10);
    chk("t3_acc", 32'(acc_cnt - a0), 32'd1);
    chk("t3_pix", 32'(acc_pix), 32'(PIX_B));

    // Malformed 20-tick pulse mid-pixel, then resynchronisation.
    idle_low(450);
    a0 = acc_cnt; e0 = err_cnt;
    send_range(PIX_C, 23, 19);
    din = 1'b1;
    repeat (20) tick();
    idle_low(20);
    chk("t4_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_no_acc", 32'(acc_cnt - a0), 32'd0);
    send_range(PIX_C, 23, 0);
    idle_low(10);
    chk("t4_ignored", 32'(acc_cnt - a0), 32'd0);
    idle_low(450);
    send_range(PIX_D, 23, 0);
    idle_low(10);
    chk("t4_acc", 32'(acc_cnt - a0), 32'd1);
    chk("t4_pix", 32'(acc_pix), 32'(PIX_D));
    chk("t4_err_total", 32'(err_cnt - e0), 32'd1);

    // Reset pulse after bit 10 of a pixel.
    idle_low(450);
    a0 = acc_cnt; e0 = err_cnt;
    send_range(PIX_E, 23, 14);
    reset_n = 1'b0;
    tick();
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_fs", 32'(frame_start), 32'd0);
    chk("t5_err", 32'(error), 32'd0);
    chk("t5_dout", 32'(dout), 32'd0);
    chk("t5_rgb", 32'({green, red, blue}), 32'd0);
    reset_n = 1'b1;
    send_range(PIX_E, 13, 0);
    idle_low(10);
    chk("t5_ignored", 32'(acc_cnt - a0), 32'd0);
    idle_low(450);
    send_range(PIX_E, 23, 0);
    idle_low(10);
    chk("t5_acc", 32'(acc_cnt - a0), 32'd1);
    chk("t5_pix", 32'(acc_pix), 32'(PIX_E));
    chk("t5_err_none", 32'(err_cnt - e0), 32'd0);

    // Two pixels in one frame: only the first decodes, the second is forwarded.
    idle_low(450);
    a0 = acc_cnt; e0 = err_cnt; d0 = dout_hi;
    send_range(PIX_F, 23, 0);
    chk("t6_dout_pix1", 32'(dout_hi - d0), 32'd0);
    chk("t6_acc1", 32'(acc_cnt - a0), 32'd1);
    chk("t6_pix", 32'(acc_pix), 32'(PIX_F));
    send_fwd(PIX_G, bad);
    chk("t6_fwd_track", 32'(bad), 32'd0);
    idle_low(10);
    chk("t6_one_valid", 32'(acc_cnt - a0), 32'd1);
    chk("t6_err", 32'(err_cnt - e0), 32'd0);
`ifndef PIXEL_RECEIVER_FWD_EN
    chk("dout_const", 32'(dout_hi), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_receiver.md
PIXEL_RECEIVER -- requirements
Module: pixel_receiver

Interface
REQ-001 SHALL have parameter TCK_THRESH, default 9: synchronized high-pulse length in clk ticks at or above which a bit decodes as 1; below it decodes as 0.
REQ-002 SHALL have parameter TCK_MAX_HI, default 16: high-pulse length in ticks above which the pulse is malformed.
REQ-003 SHALL have parameter TCK_RESET_MIN, default 400: continuous low length in ticks that signals a frame reset.
REQ-004 SHALL have parameter CNT_COLOR, default 24: number of bits per pixel.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port din, input, 1 bit: asynchronous WS2812B serial line.
REQ-008 SHALL have ports red, green, blue, output, 8 bits each: decoded pixel colour channels.
REQ-009 SHALL have port valid, output, 1 bit: the pixel on red/green/blue is available.
REQ-010 SHALL have port ready, input, 1 bit: the consumer accepts the pixel when valid and ready are both high.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse on frame-reset detection.
REQ-012 SHALL have port error, output, 1 bit: one-cycle pulse on a malformed pulse, a truncated pixel, or an overrun.
REQ-013 SHALL have port dout, output, 1 bit: serial stream forwarded to the next device in the chain.

Function
REQ-014 SHALL pass din through a 2-flop synchronizer, producing din_s; all decoding uses din_s only.
REQ-015 SHALL implement states SYNC, LOW and HIGH, and SHALL enter SYNC on reset.
REQ-016 In SYNC, SHALL ignore high pulses and SHALL go to LOW once din_s has been low for TCK_RESET_MIN consecutive cycles.
REQ-017 In LOW, a din_s rise SHALL move the state to HIGH and clear hi_cnt; the low counter SHALL saturate at TCK_RESET_MIN.
REQ-018 In HIGH, hi_cnt SHALL increment each cycle and saturate at TCK_MAX_HI+1; a din_s fall SHALL move the state to LOW and classify the bit.
REQ-019 SHALL decode a pulse with hi_cnt >= TCK_THRESH as 1, and any other pulse as 0.
REQ-020 SHALL shift decoded bits in MSB first with channel order G, R, B; bit 23 SHALL be green[7], and bit 0 SHALL be blue[0].
REQ-021 If hi_cnt exceeds TCK_MAX_HI, SHALL discard the bit, clear the bit counter, pulse error and go to SYNC.
REQ-022 A continuous low of TCK_RESET_MIN cycles in LOW SHALL pulse frame_start and clear the bit counter and first_done.
REQ-023 If the bit counter is nonzero at that frame reset, SHALL also pulse error in the same cycle.
REQ-024 On the CNT_COLOR-th bit of the frame's first pixel, SHALL load red/green/blue and assert valid on the next cycle; latency from the raw din fall to valid SHALL be 3 cycles.
REQ-025 After each completed pixel, SHALL clear the bit counter; first_done SHALL go high when the frame's first pixel completes, and later pixels in the same frame SHALL not be decoded.
REQ-026 valid SHALL stay high and red/green/blue SHALL stay stable until the handshake completes; valid SHALL drop the cycle after acceptance unless a new pixel loads in that same cycle.
REQ-027 Acceptance and a new pixel completing in the same cycle: SHALL deliver the old pixel, load the new one, and keep valid high.
REQ-028 A pixel completing while valid=1 and ready=0 SHALL be dropped, with error pulsed; the held pixel SHALL be unchanged.

Reset
REQ-029 With reset_n low at a clk edge, SHALL clear valid, frame_start, error, dout, red, green, blue, the counters, first_done and the synchronizer, and SHALL set state to SYNC.
REQ-030 Reset asserted mid-pixel or mid-handshake SHALL discard the pixel; after release, no bit SHALL decode until SYNC completes.

Configuration
REQ-031 With macro PIXEL_RECEIVER_FWD_EN defined, dout SHALL equal din_s while first_done=1 and 0 otherwise; forwarding latency from din SHALL be 2 cycles, and forwarding SHALL begin with the first high pulse after the pixel completes.
REQ-032 Without PIXEL_RECEIVER_FWD_EN, dout SHALL be constant 0 and no forwarding logic SHALL be synthesized; decoding SHALL be identical in both builds.

Verification
REQ-033 Stimulus: release reset; hold din low 400 cycles; send 24 bits encoding G=0xA5 R=0x3C B=0x0F (highs 11/6 ticks, period 18); ready=1. Response: one frame_start pulse; valid high for 1 cycle with green=0xA5, red=0x3C, blue=0x0F.
REQ-034 Stimulus: same pixel with ready=0 for 100 cycles, then ready=1. Response: valid held and data stable throughout; valid drops the cycle after acceptance.
REQ-035 Stimulus: FWD_EN build; two pixels 0x112233 then 0x445566. Response: pixel 1 decoded; dout stays 0 during pixel 1 and then replicates pixel 2's pulses delayed 2 cycles; no second valid.
REQ-036 Stimulus: a 20-tick high pulse mid-pixel. Response: error pulse; no valid; no decode until 400 low cycles elapse, after which the next pixel decodes correctly.
REQ-037 Stimulus: 12 bits, then 400 low cycles. Response: frame_start and error in the same cycle; no valid; the next 24 bits decode as a new pixel.
REQ-038 Stimulus: reset_n low for 1 cycle at bit 10 of a pixel. Response: all outputs 0 the next cycle; the remaining bits are ignored until 400 low cycles elapse.
